// File: rtl/stage_mem_pkg.sv
// Shared encodings for the MEM stage: memory op, access size, WB select and LSU FSM state.
package stage_mem_pkg;

    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_LOAD  = 2'b01;
    localparam logic [1:0] MEM_STORE = 2'b10;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam logic RD_SEL_DMEM = 1'b0;
    localparam logic RD_SEL_ALU  = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } lsu_state_e;

endpackage

// File: rtl/stage_mem_lsu_align.sv
// Byte-lane helper: store byte enables / lane replication and misalign detect for the
// request side, right-shift and sign/zero extension for the (latched) load side.
module lsu_align
    import stage_mem_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [1:0]      size_i,
    input  logic [1:0]      off_i,
    input  logic [XLEN-1:0] sd_i,
    output logic [3:0]      be_o,
    output logic [XLEN-1:0] wdata_o,
    output logic            misalign_o,
    input  logic [1:0]      ld_size_i,
    input  logic [1:0]      ld_off_i,
    input  logic            ld_uns_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [XLEN-1:0] ld_data_o
);

    logic [XLEN-1:0] raw;

    always_comb begin
        be_o       = 4'b1111;
        wdata_o    = sd_i;
        misalign_o = (off_i != 2'b00);
        case (size_i)
            SZ_B: begin
                be_o       = 4'b0001 << off_i;
                wdata_o    = {4{sd_i[7:0]}};
                misalign_o = 1'b0;
            end
            SZ_H: begin
                be_o       = 4'b0011 << {off_i[1], 1'b0};
                wdata_o    = {2{sd_i[15:0]}};
                misalign_o = off_i[0];
            end
            default: ;
        endcase
    end

    always_comb begin
        raw       = rdata_i >> {ld_off_i, 3'b000};
        ld_data_o = raw;
        case (ld_size_i)
            SZ_B:    ld_data_o = {{(XLEN-8){~ld_uns_i & raw[7]}}, raw[7:0]};
            SZ_H:    ld_data_o = {{(XLEN-16){~ld_uns_i & raw[15]}}, raw[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/stage_mem_lsu.sv
// MEM stage with MEM/WB register: issues loads/stores on a req/ack port, stalls upstream until
// the access completes or times out, and registers aligned load data toward WB.
module stage_mem_lsu
    import stage_mem_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned REG_AW      = 5,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              valid_i,
    input  logic              flush_i,
    input  logic [1:0]        mem_op_i,
    input  logic [1:0]        mem_size_i,
    input  logic              mem_uns_i,
    input  logic [XLEN-1:0]   alu_result_i,
    input  logic [XLEN-1:0]   store_data_i,
    input  logic [REG_AW-1:0] rd_waddr_i,
    input  logic              rd_wena_i,
    input  logic              rd_sel_i,
    output logic              stall_o,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [XLEN-1:0]   dmem_addr_o,
    output logic [3:0]        dmem_be_o,
    output logic [XLEN-1:0]   dmem_wdata_o,
    input  logic              dmem_ack_i,
    input  logic [XLEN-1:0]   dmem_rdata_i,
    output logic [REG_AW-1:0] rd_waddr_o,
    output logic              rd_wena_o,
    output logic              rd_sel_o,
    output logic [XLEN-1:0]   alu_result_o,
    output logic [XLEN-1:0]   dmem_data_o,
    output logic              misalign_o,
    output logic              bus_err_o
);

    localparam int unsigned CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

    lsu_state_e        state_q;
    logic [CW-1:0]     cnt_q;
    logic              kill_q;
    logic              req_q, we_q, uns_q;
    logic [XLEN-1:0]   addr_q, wdata_q;
    logic [3:0]        be_q;
    logic [1:0]        size_q, off_q;
    logic [REG_AW-1:0] lat_waddr_q;
    logic              lat_wena_q, lat_sel_q;
    logic [XLEN-1:0]   lat_alu_q;
    logic [REG_AW-1:0] rd_waddr_q;
    logic              rd_wena_q, rd_sel_q, misalign_q, bus_err_q;
    logic [XLEN-1:0]   alu_q, data_q;

    logic [3:0]        be_c;
    logic [XLEN-1:0]   wdata_c, ld_data_c;
    logic              misal_c, is_mem, issue, timeout_hit;

    lsu_align #(.XLEN(XLEN)) u_align (
        .size_i     (mem_size_i),
        .off_i      (alu_result_i[1:0]),
        .sd_i       (store_data_i),
        .be_o       (be_c),
        .wdata_o    (wdata_c),
        .misalign_o (misal_c),
        .ld_size_i  (size_q),
        .ld_off_i   (off_q),
        .ld_uns_i   (uns_q),
        .rdata_i    (dmem_rdata_i),
        .ld_data_o  (ld_data_c)
    );

    assign is_mem      = (mem_op_i == MEM_LOAD) || (mem_op_i == MEM_STORE);
    assign issue       = valid_i && is_mem && !misal_c && !flush_i;
    assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_q == TO_LAST);
    // A timing-out access releases upstream in the same cycle, just like an ack.
    assign stall_o     = (state_q == ST_IDLE) ? issue : !(dmem_ack_i || timeout_hit);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            kill_q      <= 1'b0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            uns_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            size_q      <= SZ_B;
            off_q       <= '0;
            lat_waddr_q <= '0;
            lat_wena_q  <= 1'b0;
            lat_sel_q   <= RD_SEL_DMEM;
            lat_alu_q   <= '0;
            rd_waddr_q  <= '0;
            rd_wena_q   <= 1'b0;
            rd_sel_q    <= RD_SEL_DMEM;
            alu_q       <= '0;
            data_q      <= '0;
            misalign_q  <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    rd_wena_q <= 1'b0;
                    if (issue) begin
                        state_q     <= ST_WAIT;
                        req_q       <= 1'b1;
                        cnt_q       <= '0;
                        kill_q      <= 1'b0;
                        addr_q      <= {alu_result_i[XLEN-1:2], 2'b00};
                        off_q       <= alu_result_i[1:0];
                        we_q        <= (mem_op_i == MEM_STORE);
                        be_q        <= be_c;
                        wdata_q     <= wdata_c;
                        size_q      <= mem_size_i;
                        uns_q       <= mem_uns_i;
                        lat_waddr_q <= rd_waddr_i;
                        lat_wena_q  <= rd_wena_i;
                        lat_sel_q   <= rd_sel_i;
                        lat_alu_q   <= alu_result_i;
                    end else if (valid_i && !flush_i && !is_mem) begin
                        rd_waddr_q <= rd_waddr_i;
                        rd_wena_q  <= rd_wena_i;
                        rd_sel_q   <= rd_sel_i;
                        alu_q      <= alu_result_i;
                        data_q     <= '0;
                    end else begin
                        misalign_q <= valid_i && !flush_i && is_mem && misal_c;
                    end
                end
                ST_WAIT: begin
                    if (dmem_ack_i) begin
                        state_q    <= ST_IDLE;
                        req_q      <= 1'b0;
                        rd_waddr_q <= lat_waddr_q;
                        rd_wena_q  <= lat_wena_q && !kill_q && !flush_i;
                        rd_sel_q   <= lat_sel_q;
                        alu_q      <= lat_alu_q;
                        data_q     <= we_q ? '0 : ld_data_c;
                    end else if (timeout_hit) begin
                        state_q   <= ST_IDLE;
                        req_q     <= 1'b0;
                        rd_wena_q <= 1'b0;
                        bus_err_q <= 1'b1;
                    end else begin
                        cnt_q     <= cnt_q + 1'b1;
                        kill_q    <= kill_q || flush_i;
                        rd_wena_q <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign dmem_req_o   = req_q;
    assign dmem_we_o    = we_q;
    assign dmem_addr_o  = addr_q;
    assign dmem_be_o    = be_q;
    assign dmem_wdata_o = wdata_q;
    assign rd_waddr_o   = rd_waddr_q;
    assign rd_wena_o    = rd_wena_q;
    assign rd_sel_o     = rd_sel_q;
    assign alu_result_o = alu_q;
    assign dmem_data_o  = data_q;
    assign misalign_o   = misalign_q;
    assign bus_err_o    = bus_err_q;

endmodule

// File: tb/tb_stage_mem_lsu.sv
// Directed bench for stage_mem_lsu: ALU pass-through, loads/stores, misalign, timeout, flush, reset.
module tb_stage_mem_lsu;
    import stage_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, valid, flush, uns, we_i, sel, ack;
    logic [1:0]  op, sz;
    logic [31:0] alu, sd, rdata;
    logic [4:0]  rd;
    logic        stall, req, we, wena_o, sel_o, misal, berr;
    logic [31:0] addr, wdata, alu_o, data_o;
    logic [3:0]  be;
    logic [4:0]  waddr_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    stage_mem_lsu #(.XLEN(32), .REG_AW(5), .TIMEOUT_CYC(4)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid), .flush_i(flush),
        .mem_op_i(op), .mem_size_i(sz), .mem_uns_i(uns), .alu_result_i(alu),
        .store_data_i(sd), .rd_waddr_i(rd), .rd_wena_i(we_i), .rd_sel_i(sel),
        .stall_o(stall), .dmem_req_o(req), .dmem_we_o(we), .dmem_addr_o(addr),
        .dmem_be_o(be), .dmem_wdata_o(wdata), .dmem_ack_i(ack), .dmem_rdata_i(rdata),
        .rd_waddr_o(waddr_o), .rd_wena_o(wena_o), .rd_sel_o(sel_o),
        .alu_result_o(alu_o), .dmem_data_o(data_o), .misalign_o(misal), .bus_err_o(berr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] o, input logic [1:0] s, input logic u,
                         input logic [31:0] a, input logic [31:0] d, input logic [4:0] r,
                         input logic w, input logic se);
        valid = v; op = o; sz = s; uns = u; alu = a; sd = d; rd = r; we_i = w; sel = se;
    endtask

    task automatic run_lb(input logic u, input logic [31:0] expv);
        int stalls = 0;
        @(negedge clk);
        drive(1'b1, MEM_LOAD, SZ_B, u, 32'h103, 32'h0, 5'd7, 1'b1, RD_SEL_DMEM);
        #1 if (stall) stalls++;
        chk("lb_req_idle", {31'd0, req}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) begin
                chk("lb_req", {31'd0, req}, 32'd1);
                chk("lb_be", {28'd0, be}, 32'h8);
                chk("lb_addr", addr, 32'h100);
                chk("lb_we", {31'd0, we}, 32'd0);
            end
            if (i == 3) begin ack = 1'b1; rdata = 32'h80FFFFFF; end
            #1 if (stall) stalls++;
        end
        @(negedge clk);
        ack = 1'b0; valid = 1'b0; rdata = 32'hDEADBEEF;
        chk("lb_req_done", {31'd0, req}, 32'd0);
        chk("lb_wena", {31'd0, wena_o}, 32'd1);
        chk("lb_waddr", {27'd0, waddr_o}, 32'd7);
        chk("lb_sel", {31'd0, sel_o}, 32'd0);
        chk("lb_data", data_o, expv);
        chk("lb_stalls", stalls, 32'd4);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; ack = 1'b0; rdata = 32'hDEADBEEF;
        drive(1'b0, MEM_NONE, SZ_W, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        chk("rst_wena", {31'd0, wena_o}, 32'd0);
        chk("rst_req", {31'd0, req}, 32'd0);
        chk("rst_alu", alu_o, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        rst_n = 1'b1;

        // ALU op
        @(negedge clk);
        drive(1'b1, MEM_NONE, SZ_W, 1'b0, 32'h1234, 32'h0, 5'd5, 1'b1, RD_SEL_ALU);
        #1 chk("alu_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        valid = 1'b0;
        chk("alu_waddr", {27'd0, waddr_o}, 32'd5);
        chk("alu_wena", {31'd0, wena_o}, 32'd1);
        chk("alu_res", alu_o, 32'h1234);
        chk("alu_sel", {31'd0, sel_o}, 32'd1);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk("idle_ack_wena", {31'd0, wena_o}, 32'd0);
        chk("idle_ack_req", {31'd0, req}, 32'd0);

        // LB signed / unsigned at lane 3
        run_lb(1'b0, 32'hFFFFFF80);
        run_lb(1'b1, 32'h00000080);

        // SH at upper half
        @(negedge clk);
        drive(1'b1, MEM_STORE, SZ_H, 1'b0, 32'h202, 32'hABCD, 5'd0, 1'b0, RD_SEL_ALU);
        @(negedge clk);
        chk("sh_be", {28'd0, be}, 32'hC);
        chk("sh_wdata", wdata, 32'hABCDABCD);
        chk("sh_we", {31'd0, we}, 32'd1);
        chk("sh_addr", addr, 32'h200);
        sd = 32'h1111;
        @(negedge clk);
        chk("sh_wdata_hold", wdata, 32'hABCDABCD);
        chk("sh_be_hold", {28'd0, be}, 32'hC);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0; valid = 1'b0;
        chk("sh_req_done", {31'd0, req}, 32'd0);
        chk("sh_data", data_o, 32'd0);

        // Misaligned LW
        @(negedge clk);
        drive(1'b1, MEM_LOAD, SZ_W, 1'b0, 32'h101, 32'h0, 5'd4, 1'b1, RD_SEL_DMEM);
        #1 chk("mis_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        valid = 1'b0;
        chk("mis_req", {31'd0, req}, 32'd0);
        chk("mis_pulse", {31'd0, misal}, 32'd1);
        chk("mis_wena", {31'd0, wena_o}, 32'd0);
        @(negedge clk);
        chk("mis_pulse_end", {31'd0, misal}, 32'd0);

        // Timeout, no ack
        @(negedge clk);
        drive(1'b1, MEM_LOAD, SZ_W, 1'b0, 32'h300, 32'h0, 5'd9, 1'b1, RD_SEL_DMEM);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("to_req", {31'd0, req}, 32'd1);
            if (i == 3) valid = 1'b0;
        end
        @(negedge clk);
        #1;
        chk("to_req_drop", {31'd0, req}, 32'd0);
        chk("to_berr", {31'd0, berr}, 32'd1);
        chk("to_wena", {31'd0, wena_o}, 32'd0);
        chk("to_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        chk("to_berr_end", {31'd0, berr}, 32'd0);

        // Ack in the timeout cycle wins
        drive(1'b1, MEM_LOAD, SZ_W, 1'b0, 32'h300, 32'h0, 5'd9, 1'b1, RD_SEL_DMEM);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 3) begin ack = 1'b1; rdata = 32'h11223344; end
        end
        @(negedge clk);
        ack = 1'b0; valid = 1'b0; rdata = 32'hDEADBEEF;
        chk("ackto_berr", {31'd0, berr}, 32'd0);
        chk("ackto_wena", {31'd0, wena_o}, 32'd1);
        chk("ackto_data", data_o, 32'h11223344);

        // Flush during WAIT
        @(negedge clk);
        drive(1'b1, MEM_LOAD, SZ_H, 1'b1, 32'h402, 32'h0, 5'd3, 1'b1, RD_SEL_DMEM);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("fl_req_cont", {31'd0, req}, 32'd1);
        @(negedge clk);
        ack = 1'b1; rdata = 32'hBEEF0000;
        @(negedge clk);
        ack = 1'b0; valid = 1'b0;
        chk("fl_req_done", {31'd0, req}, 32'd0);
        chk("fl_wena", {31'd0, wena_o}, 32'd0);
        chk("fl_berr", {31'd0, berr}, 32'd0);

        // Reset mid-WAIT
        @(negedge clk);
        drive(1'b1, MEM_LOAD, SZ_B, 1'b0, 32'h500, 32'h0, 5'd2, 1'b1, RD_SEL_DMEM);
        @(negedge clk);
        chk("rw_req", {31'd0, req}, 32'd1);
        rst_n = 1'b0; valid = 1'b0;
        @(negedge clk);
        chk("rw_req_drop", {31'd0, req}, 32'd0);
        chk("rw_waddr", {27'd0, waddr_o}, 32'd0);
        chk("rw_alu", alu_o, 32'd0);
        chk("rw_data", data_o, 32'd0);
        chk("rw_stall", {31'd0, stall}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
